// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  // Widest controller count the helpers are sized for.
  localparam int MAX_N = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot vector with bit idx set, limited to the lowest n bits.
  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    logic [MAX_N-1:0] v;
    v = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if ((k == idx) && (k < n)) v[k] = 1'b1;
      else v[k] = 1'b0;
    end
    return v;
  endfunction

  // Bits needed to hold an outstanding count from 0 up to max_out.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of controller-side and device-side Wishbone signals around the arbiter.
interface wb_rr_arbiter_if #(
  parameter int N_CTRL     = 4,
  parameter int DATA_WIDTH = 8
);
  logic [N_CTRL-1:0]            cyc_i;
  logic [N_CTRL-1:0]            stb_i;
  logic [N_CTRL*DATA_WIDTH-1:0] dat_i;
  logic [N_CTRL-1:0]            stall_o;
  logic [N_CTRL-1:0]            ack_o;
  logic [N_CTRL-1:0]            grant_o;
  logic                         cyc_o;
  logic                         stb_o;
  logic [DATA_WIDTH-1:0]        dat_o;
  logic                         stall_i;
  logic                         ack_i;

  // Arbiter side.
  modport slave (
    input  cyc_i, stb_i, dat_i, stall_i, ack_i,
    output stall_o, ack_o, grant_o, cyc_o, stb_o, dat_o
  );

  // Controllers plus shared device side.
  modport master (
    output cyc_i, stb_i, dat_i, stall_i, ack_i,
    input  stall_o, ack_o, grant_o, cyc_o, stb_o, dat_o
  );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Round-robin pick: first set request bit strictly after last, wrapping around.
module wb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [N-1:0]   above_s;
  logic [2*N-1:0] dbl_s;
  logic [IW:0]    first_s;

  // Lower half holds requests above last, upper half all requests (the wrap).
  always_comb begin
    above_s = '0;
    for (int k = 0; k < N; k++) begin
      if (k > int'(last_i)) above_s[k] = 1'b1;
      else above_s[k] = 1'b0;
    end
    dbl_s = {req_i, req_i & above_s};
    first_s = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl_s[j]) first_s = (IW+1)'(j);
      else first_s = first_s;
    end
    valid_o = |req_i;
    if (first_s >= (IW+1)'(N)) idx_o = IW'(first_s - (IW+1)'(N));
    else idx_o = first_s[IW-1:0];
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone device among N_CTRL controllers.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_CTRL     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_OUT    = 4
) (
  input logic            clk_i,
  input logic            rst_ni,
  wb_rr_arbiter_if.slave bus
);
  localparam int IW = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
  localparam int CW = cnt_width(MAX_OUT);
  localparam logic [IW-1:0] LAST_RST = IW'(N_CTRL - 1);
  localparam logic [CW-1:0] OUT_FULL = CW'(MAX_OUT);

  arb_state_t            state_r, state_nxt_s;
  logic [IW-1:0]         owner_r, owner_nxt_s, last_r, last_nxt_s;
  logic [CW-1:0]         out_r, out_nxt_s, cnt_nxt_s;
  logic [N_CTRL-1:0]     grant_r, grant_nxt_s;
  logic [MAX_N-1:0]      own_oh_w_s, pick_oh_w_s;
  logic [N_CTRL-1:0]     own_oh_s, pick_oh_s, pick_req_s;
  logic [IW-1:0]         pick_last_s, pick_idx_s;
  logic                  pick_valid_s;
  logic                  full_s, accept_s, ret_s, cyc_s, stb_s;
  logic [DATA_WIDTH-1:0] dat_s;
  logic [N_CTRL-1:0]     ack_s, stall_s;

  assign own_oh_w_s  = onehot(int'(owner_r), N_CTRL);
  assign own_oh_s    = own_oh_w_s[N_CTRL-1:0];
  assign pick_oh_w_s = onehot(int'(pick_idx_s), N_CTRL);
  assign pick_oh_s   = pick_oh_w_s[N_CTRL-1:0];
  assign full_s      = (out_r == OUT_FULL);

  // Idle: search all requests after last; handover: exclude the departing owner, search after it.
  always_comb begin
    if (state_r == GRANT) begin
      pick_req_s  = bus.cyc_i & ~own_oh_s;
      pick_last_s = owner_r;
    end else begin
      pick_req_s  = bus.cyc_i;
      pick_last_s = last_r;
    end
  end

  wb_rr_pick #(.N(N_CTRL), .IW(IW)) u_pick (
    .req_i   (pick_req_s),
    .last_i  (pick_last_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // Route the owner onto the device and device responses back to the owner only.
  always_comb begin
    cyc_s   = 1'b0;
    stb_s   = 1'b0;
    dat_s   = '0;
    ack_s   = '0;
    stall_s = bus.cyc_i & bus.stb_i;
    if (state_r == GRANT) begin
      cyc_s          = bus.cyc_i[owner_r];
      stb_s          = bus.cyc_i[owner_r] & bus.stb_i[owner_r] & ~full_s;
      dat_s          = bus.dat_i[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
      ack_s[owner_r] = bus.ack_i & bus.cyc_i[owner_r];
      stall_s[owner_r] = bus.cyc_i[owner_r] & bus.stb_i[owner_r] & (bus.stall_i | full_s);
    end else begin
      cyc_s = 1'b0;
    end
  end

  assign bus.cyc_o   = cyc_s;
  assign bus.stb_o   = stb_s;
  assign bus.dat_o   = dat_s;
  assign bus.ack_o   = ack_s;
  assign bus.stall_o = stall_s;
  assign bus.grant_o = grant_r;

  // Outstanding count: acks arriving with nothing outstanding are ignored.
  always_comb begin
    accept_s = stb_s & ~bus.stall_i;
    ret_s    = bus.ack_i & cyc_s;
    if (accept_s && !ret_s) cnt_nxt_s = out_r + CW'(1);
    else if (ret_s && !accept_s && (out_r != '0)) cnt_nxt_s = out_r - CW'(1);
    else cnt_nxt_s = out_r;
  end

  // Grant FSM: pick an owner, hold it while cyc is high, hand over on release.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    out_nxt_s   = out_r;
    grant_nxt_s = grant_r;
    case (state_r)
      IDLE: begin
        out_nxt_s = '0;
        if (pick_valid_s) begin
          state_nxt_s = GRANT;
          owner_nxt_s = pick_idx_s;
          grant_nxt_s = pick_oh_s;
        end else begin
          grant_nxt_s = '0;
        end
      end
      GRANT: begin
        if (!bus.cyc_i[owner_r]) begin
          last_nxt_s = owner_r;
          out_nxt_s  = '0;
          if (pick_valid_s) begin
            owner_nxt_s = pick_idx_s;
            grant_nxt_s = pick_oh_s;
          end else begin
            state_nxt_s = IDLE;
            grant_nxt_s = '0;
          end
        end else begin
          out_nxt_s = cnt_nxt_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        out_nxt_s   = '0;
        grant_nxt_s = '0;
      end
    endcase
  end

  // State registers; reset drops any in-flight downstream cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      owner_r <= '0;
      last_r  <= LAST_RST;
      out_r   <= '0;
      grant_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
      out_r   <= out_nxt_s;
      grant_r <= grant_nxt_s;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (N_CTRL=4, DATA_WIDTH=8, MAX_OUT=4).
module tb_wb_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  wb_rr_arbiter_if #(.N_CTRL(4), .DATA_WIDTH(8)) bus ();

  wb_rr_arbiter #(.N_CTRL(4), .DATA_WIDTH(8), .MAX_OUT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; return 1 time unit after the last rising edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.cyc_i = 4'b1010; bus.stb_i = 4'b1000; bus.dat_i = 32'h0;
    bus.stall_i = 1'b0; bus.ack_i = 1'b1;
    adv(2);
    // Reset state
    chk("rst_grant", 32'(bus.grant_o), 32'h0);
    chk("rst_cyc", 32'(bus.cyc_o), 32'h0);
    chk("rst_stb", 32'(bus.stb_o), 32'h0);
    chk("rst_dat", 32'(bus.dat_o), 32'h0);
    chk("rst_ack", 32'(bus.ack_o), 32'h0);
    chk("rst_stall", 32'(bus.stall_o), 32'h8);
    chk("rst_out", 32'(dut.out_r), 32'h0);

    // Reset mid-grant: owner 2 builds up 3 outstanding
    rst_n = 1'b1; bus.ack_i = 1'b0;
    bus.cyc_i = 4'b0100; bus.stb_i = 4'b0100;
    adv(1);
    chk("mg_grant", 32'(bus.grant_o), 32'h4);
    adv(3);
    chk("mg_out3", 32'(dut.out_r), 32'h3);
    rst_n = 1'b0; bus.stb_i = 4'b0000;
    adv(1);
    rst_n = 1'b1;
    chk("mg_rst_grant", 32'(bus.grant_o), 32'h0);
    chk("mg_rst_cyc", 32'(bus.cyc_o), 32'h0);
    chk("mg_rst_out", 32'(dut.out_r), 32'h0);
    bus.cyc_i = 4'b1111;
    adv(1);
    chk("mg_all_winner0", 32'(bus.grant_o), 32'h1);

    // Round robin: each owner one beat + ack, then drops cyc
    for (int k = 0; k < 4; k++) begin
      bus.stb_i = 4'(1 << k);
      #1 chk("rr_stb", 32'(bus.stb_o), 32'h1);
      adv(1);
      bus.stb_i = 4'b0000; bus.ack_i = 1'b1;
      #1 chk("rr_ack", 32'(bus.ack_o), 32'(1 << k));
      adv(1);
      bus.ack_i = 1'b0; bus.cyc_i[k] = 1'b0;
      adv(1);
      chk("rr_next_grant", 32'(bus.grant_o), 32'(1 << ((k + 1) % 4)));
      chk("rr_no_idle", 32'(bus.cyc_o), 32'h1);
      bus.cyc_i[k] = 1'b1;
    end

    // Outstanding limit: owner 0 streams, device withholds acks
    bus.cyc_i = 4'b0001; bus.stb_i = 4'b0001;
    adv(4);
    chk("lim_out4", 32'(dut.out_r), 32'h4);
    chk("lim_stall", 32'(bus.stall_o), 32'h1);
    chk("lim_stb0", 32'(bus.stb_o), 32'h0);
    adv(2);
    chk("lim_out_hold", 32'(dut.out_r), 32'h4);
    bus.ack_i = 1'b1;
    #1 chk("lim_ack", 32'(bus.ack_o), 32'h1);
    chk("lim_stb_still0", 32'(bus.stb_o), 32'h0);
    adv(1);
    bus.ack_i = 1'b0;
    chk("lim_out3", 32'(dut.out_r), 32'h3);
    chk("lim_stb_resume", 32'(bus.stb_o), 32'h1);
    chk("lim_stall_clear", 32'(bus.stall_o), 32'h0);
    adv(1);
    chk("lim_out_refill", 32'(dut.out_r), 32'h4);
    bus.stb_i = 4'b0000; bus.ack_i = 1'b1;
    adv(4);
    chk("lim_drain", 32'(dut.out_r), 32'h0);
    bus.ack_i = 1'b0; bus.cyc_i = 4'b0000;
    adv(1);
    chk("lim_idle", 32'(bus.grant_o), 32'h0);

    // Downstream stall passthrough with owner 1, non-owner 3 strobing
    bus.cyc_i = 4'b1010;
    adv(1);
    chk("st_grant", 32'(bus.grant_o), 32'h2);
    bus.stb_i = 4'b1010; bus.stall_i = 1'b1; bus.dat_i[8 +: 8] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1 chk("st_stall", 32'(bus.stall_o), 32'ha);
      adv(1);
    end
    chk("st_no_accept", 32'(dut.out_r), 32'h0);
    bus.stall_i = 1'b0;
    #1 chk("st_release", 32'(bus.stall_o), 32'h8);
    chk("st_dat", 32'(bus.dat_o), 32'h55);
    adv(1);
    bus.stb_i = 4'b1000;
    chk("st_one_accept", 32'(dut.out_r), 32'h1);
    bus.ack_i = 1'b1;
    adv(1);
    bus.ack_i = 1'b0; bus.cyc_i = 4'b0000; bus.stb_i = 4'b0000;
    adv(1);

    // Owner abort: owner 0 drops with 2 outstanding while 2 requests
    bus.cyc_i = 4'b0001;
    adv(1);
    chk("ab_grant0", 32'(bus.grant_o), 32'h1);
    bus.stb_i = 4'b0001; bus.cyc_i = 4'b0101;
    adv(2);
    chk("ab_out2", 32'(dut.out_r), 32'h2);
    bus.cyc_i = 4'b0100; bus.stb_i = 4'b0000;
    #1 chk("ab_cyc_drop", 32'(bus.cyc_o), 32'h0);
    adv(1);
    chk("ab_grant2", 32'(bus.grant_o), 32'h4);
    chk("ab_out_clear", 32'(dut.out_r), 32'h0);
    bus.ack_i = 1'b1;
    #1 chk("ab_late_ack0", 32'(bus.ack_o[0]), 32'h0);
    adv(1);
    chk("ab_no_wrap", 32'(dut.out_r), 32'h0);
    bus.ack_i = 1'b0; bus.cyc_i = 4'b0000;
    adv(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
